adc_overload_detector: RTL and testbench
========================================

Name: adc_overload_detector

Overview:
- Upstream stage of the AGC: watches raw signed ADC samples and produces the one-bit `overload` flag that the AGC ORs into its envelope indicator.
- Computes the sample magnitude and compares it against a programmable threshold.
- Requires a programmable number of consecutive over-threshold samples before asserting `overload`, then holds it for a programmable time.
- Also reports the windowed peak magnitude for gain-table calibration.

Parameters:
- DATA_W, 16, ADC sample width (signed two's complement).
- WIN_W, 8, peak window length is 2^WIN_W valid samples.

Ports:
- clk  in  1  clock.
- RESETn  in  1  synchronous, active-low reset.
- enable  in  1  detector on; 0 forces IDLE.
- clear  in  1  synchronous soft clear of counters, peak and FSM.
- sample_valid  in  1  `sample` is a new ADC word this cycle.
- sample  in  DATA_W  signed ADC sample.
- threshold  in  DATA_W-1  unsigned magnitude trip level.
- min_hits  in  4  consecutive hits required to trip (0 treated as 1).
- hold_cycles  in  8  overload extension after the last hit.
- overload  out  1  registered overload flag to the AGC.
- peak_mag  out  DATA_W-1  latched peak magnitude of the last completed window.
- peak_valid  out  1  one-cycle pulse when `peak_mag` updates.

Behaviour:

Reset and clear
- RESETn=0 at a clk edge sets all of the following to 0: overload, peak_mag, peak_valid, all counters and pipeline registers. The FSM goes to IDLE.
- Reset mid-operation aborts everything, with no residual hold.
- clear=1 has the same effect as reset, except peak_mag retains its value. clear has priority over enable and sample_valid.

Stage 1 (edge E)
- mag_r = |sample|, width DATA_W-1.
- The most negative input (-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1.
- hit_r = (mag_r >= threshold) is computed from the combinational magnitude.
- vld_r = sample_valid & enable.

Stage 2 (edge E+1): FSM, hit counter and hold counter
- IDLE:
  - overload=0, hit_cnt=0.
  - enable=1 → MONITOR.
- MONITOR:
  - vld_r&hit_r: if hit_cnt+1 >= max(min_hits,1) → ASSERTED, load hold_cnt=hold_cycles, hit_cnt=0. Else hit_cnt++.
  - vld_r&!hit_r: hit_cnt=0.
  - !vld_r: hit_cnt unchanged (gaps between valid samples do not break a run).
  - hit_cnt saturates at 15.
- ASSERTED (overload=1):
  - vld_r&hit_r reloads hold_cnt=hold_cycles.
  - Otherwise, each clk: if hold_cnt==0 → MONITOR (overload=0 next cycle), else hold_cnt--.
  - Net effect: overload stays high hold_cycles+1 clocks after the last hit is processed.
- enable=0 in any state → IDLE at the next edge; overload drops that edge.

Latency
- overload rises at edge E+1, where E is the edge that registered the tripping sample (2 clocks from sample presentation).

Peak tracking (stage 2, counts only vld_r cycles)
- run_max = max(run_max, mag_r).
- win_cnt increments and wraps at 2^WIN_W.
- On the wrap sample:
  - peak_mag = max(run_max, mag_r) and peak_valid=1 for one cycle.
  - run_max restarts at 0; the wrap sample is already included in the latched peak.
- enable=0 freezes win_cnt and run_max (no reset).

Threshold and min_hits
- Treated as quasi-static; changes take effect on the next sample with no glitch requirement.
- threshold=0 means every valid sample is a hit.

Test Plan:
1. Reset/idle: RESETn=0 for 2 clk with sample=16'h7FFF, valid=1 → overload=0, peak_mag=0, peak_valid=0 throughout and one cycle after release with enable=0.
2. Trip count: enable=1, threshold=1000, min_hits=3; valid samples 1200, -1500, 900, 1100, 1300, 2000 → no trip (run broken by 900); overload rises 2 clk after the 2000 sample (the third consecutive hit).
3. Hold: after scenario 2, hold_cycles=5, then continuous valid samples of 0 → overload high exactly 6 clk after the stage-2 edge of the last hit, then 0. A hit inserted at hold_cnt==2 restarts the full 6-clk hold.
4. Saturation/edges: sample=16'h8000, threshold=15'h7FFF, min_hits=0 → trips after 1 sample. threshold=0 with all-zero samples → trips.
5. Peak window: WIN_W=8, 256 valid samples with a ramp to magnitude 4321 at index 100 (including a -4321 sample) → peak_valid pulses once on the 256th sample, peak_mag=4321. The next window of zeros → peak_mag=0.
6. Mid-operation control: while ASSERTED, drop enable for 1 clk → overload=0 next edge, FSM IDLE, hit_cnt=0. Pulse clear mid-window → peak_valid does not fire until 256 valid samples after clear, and peak_mag holds its old value until then.

Source files
------------

// File: rtl/adc_overload_detector.sv
// rtl/adc_overload_detector.sv - ADC magnitude overload detector with hit counting, hold and windowed peak.

module adc_overload_detector #(
  parameter int DATA_W = 16,
  parameter int WIN_W  = 8
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-2:0] threshold,
  input  logic [3:0]        min_hits,
  input  logic [7:0]        hold_cycles,
  output logic              overload,
  output logic [DATA_W-2:0] peak_mag,
  output logic              peak_valid
);

  typedef enum logic [1:0] {S_IDLE, S_MONITOR, S_ASSERTED} state_t;

  state_t            state;
  logic [DATA_W-1:0] neg_s;
  logic [DATA_W-2:0] mag_c;
  logic              hit_c;
  logic [DATA_W-2:0] mag_r;
  logic              hit_r;
  logic              vld_r;
  logic [3:0]        hit_cnt;
  logic [7:0]        hold_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [DATA_W-2:0] run_max;
  logic [DATA_W-2:0] max_c;
  logic [3:0]        min_eff;
  logic [4:0]        hit_next;
  logic              trip;

  // Full-scale negative has no positive twin, so it saturates to the largest magnitude.
  always_comb begin
    neg_s = -sample;
    if (!sample[DATA_W-1])
      mag_c = sample[DATA_W-2:0];
    else if (neg_s[DATA_W-1])
      mag_c = '1;
    else
      mag_c = neg_s[DATA_W-2:0];
  end

  assign hit_c    = (mag_c >= threshold);
  assign max_c    = (mag_r > run_max) ? mag_r : run_max;
  assign min_eff  = (min_hits == 4'd0) ? 4'd1 : min_hits;
  assign hit_next = {1'b0, hit_cnt} + 5'd1;
  assign trip     = (hit_next >= {1'b0, min_eff});

  always_ff @(posedge clk) begin
    if (!RESETn || clear) begin
      state      <= S_IDLE;
      overload   <= 1'b0;
      hit_cnt    <= '0;
      hold_cnt   <= '0;
      mag_r      <= '0;
      hit_r      <= 1'b0;
      vld_r      <= 1'b0;
      win_cnt    <= '0;
      run_max    <= '0;
      peak_valid <= 1'b0;
      if (!RESETn)
        peak_mag <= '0;
    end else begin
      mag_r      <= mag_c;
      hit_r      <= hit_c;
      vld_r      <= sample_valid & enable;
      peak_valid <= 1'b0;

      if (!enable) begin
        state    <= S_IDLE;
        overload <= 1'b0;
        hit_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            overload <= 1'b0;
            hit_cnt  <= '0;
            state    <= S_MONITOR;
          end
          S_MONITOR: begin
            if (vld_r && hit_r) begin
              if (trip) begin
                state    <= S_ASSERTED;
                overload <= 1'b1;
                hold_cnt <= hold_cycles;
                hit_cnt  <= '0;
              end else if (hit_cnt != 4'hF) begin
                hit_cnt <= hit_cnt + 4'd1;
              end
            end else if (vld_r) begin
              hit_cnt <= '0;
            end
          end
          S_ASSERTED: begin
            // Any processed hit restarts the full hold period.
            if (vld_r && hit_r) begin
              hold_cnt <= hold_cycles;
            end else if (hold_cnt == 8'd0) begin
              state    <= S_MONITOR;
              overload <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
            end
          end
          default: begin
            state    <= S_IDLE;
            overload <= 1'b0;
          end
        endcase
      end

      // The wrap sample is folded into the latched peak, then the running max restarts.
      if (vld_r && enable) begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (&win_cnt) begin
          peak_mag   <= max_c;
          peak_valid <= 1'b1;
          run_max    <= '0;
        end else begin
          run_max <= max_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_overload_detector.sv
// tb/tb_adc_overload_detector.sv - self-checking bench for adc_overload_detector against a sample-level model.

module tb_adc_overload_detector;

  logic        clk;
  logic        RESETn;
  logic        enable;
  logic        clear;
  logic        sample_valid;
  logic [15:0] sample;
  logic [14:0] threshold;
  logic [3:0]  min_hits;
  logic [7:0]  hold_cycles;
  logic        overload;
  logic [14:0] peak_mag;
  logic        peak_valid;

  int n_cmp = 0;
  int n_bad = 0;

  adc_overload_detector #(.DATA_W(16), .WIN_W(8)) dut (
    .clk(clk), .RESETn(RESETn), .enable(enable), .clear(clear),
    .sample_valid(sample_valid), .sample(sample), .threshold(threshold),
    .min_hits(min_hits), .hold_cycles(hold_cycles), .overload(overload),
    .peak_mag(peak_mag), .peak_valid(peak_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: a sample-level view (run length, edge of last hit, window contents).
  int  edge_n;
  bit  m_armed, m_on;
  int  m_run, m_last_hit, m_last_hold;
  bit  p_v, p_h;
  int  p_mag;
  int  win_q[$];
  int  exp_peak;
  bit  exp_pv, exp_ovl;

  function automatic int mag_of(logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic model_update();
    int mx;
    edge_n++;
    exp_pv = 0;
    if (!RESETn || clear) begin
      m_armed = 0; m_on = 0; m_run = 0;
      p_v = 0; p_h = 0; p_mag = 0;
      win_q.delete();
      if (!RESETn) exp_peak = 0;
      exp_ovl = 0;
      return;
    end
    if (!enable) begin
      m_armed = 0; m_on = 0; m_run = 0;
    end else if (!m_armed && !m_on) begin
      m_armed = 1;
    end else if (!m_on) begin
      if (p_v && p_h) begin
        m_run++;
        if (m_run >= ((min_hits == 0) ? 1 : int'(min_hits))) begin
          m_on = 1; m_armed = 0; m_run = 0;
          m_last_hit = edge_n; m_last_hold = hold_cycles;
        end
      end else if (p_v) begin
        m_run = 0;
      end
    end else begin
      if (p_v && p_h) begin
        m_last_hit = edge_n; m_last_hold = hold_cycles;
      end else if (edge_n - m_last_hit > m_last_hold) begin
        m_on = 0; m_armed = 1;
      end
    end
    exp_ovl = m_on;
    if (p_v && enable) begin
      win_q.push_back(p_mag);
      if (win_q.size() == 256) begin
        mx = 0;
        foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
        exp_peak = mx; exp_pv = 1;
        win_q.delete();
      end
    end
    p_v   = sample_valid && enable;
    p_mag = mag_of(sample);
    p_h   = (p_mag >= int'(threshold));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(bit v, int s);
    sample_valid = v;
    sample       = s[15:0];
  endtask

  task automatic test_reset();
    RESETn = 0; enable = 1; clear = 0; drive(1, 16'h7FFF);
    threshold = 15'd100; min_hits = 4'd1; hold_cycles = 8'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (overload !== 1'b0 || peak_valid !== 1'b0 || peak_mag !== 15'd0) begin
        n_bad++;
        $display("FAIL reset_hold: got ovl=%0b pv=%0b peak=%0d want 0/0/0", overload, peak_valid, peak_mag);
      end
    end
    RESETn = 1; enable = 0;
    step();
    n_cmp++;
    if (overload !== 1'b0 || peak_valid !== 1'b0 || peak_mag !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_release: got ovl=%0b pv=%0b peak=%0d want 0/0/0", overload, peak_valid, peak_mag);
    end
  endtask

  task automatic test_trip_count();
    int seq[6] = '{1200, -1500, 900, 1100, 1300, 2000};
    threshold = 15'd1000; min_hits = 4'd3; hold_cycles = 8'd5; enable = 1;
    drive(0, 0);
    step(); step();
    foreach (seq[i]) begin
      drive(1, seq[i]);
      step();
      n_cmp++;
      if (overload !== 1'b0 || overload !== exp_ovl) begin
        n_bad++;
        $display("FAIL trip_early[%0d]: got ovl=%0b want 0 (model %0b)", i, overload, exp_ovl);
      end
    end
    drive(1, 0);
    step();
    n_cmp++;
    if (overload !== 1'b1 || overload !== exp_ovl) begin
      n_bad++;
      $display("FAIL trip_latency: got ovl=%0b want 1 (model %0b)", overload, exp_ovl);
    end
  endtask

  task automatic test_hold();
    int high;
    high = 1;
    drive(1, 0);
    for (int i = 0; i < 20 && overload; i++) begin
      step();
      n_cmp++;
      if (overload !== exp_ovl) begin
        n_bad++;
        $display("FAIL hold_model: got ovl=%0b want %0b", overload, exp_ovl);
      end
      if (overload) high++;
    end
    n_cmp++;
    if (high != 6) begin
      n_bad++;
      $display("FAIL hold_len: got %0d cycles want 6", high);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 2000);
      step();
    end
    drive(1, 0);
    step();
    n_cmp++;
    if (overload !== 1'b1) begin
      n_bad++;
      $display("FAIL retrip: got ovl=%0b want 1", overload);
    end
    high = 1;
    for (int i = 0; i < 30 && overload; i++) begin
      drive(1, (i == 2) ? 2000 : 0);
      step();
      n_cmp++;
      if (overload !== exp_ovl) begin
        n_bad++;
        $display("FAIL rehold_model: got ovl=%0b want %0b", overload, exp_ovl);
      end
      if (overload) high++;
    end
    n_cmp++;
    if (high != 10) begin
      n_bad++;
      $display("FAIL rehold_len: got %0d cycles want 10", high);
    end
  endtask

  task automatic test_edges();
    clear = 1; drive(0, 0); step(); clear = 0;
    threshold = 15'h7FFF; min_hits = 4'd0; hold_cycles = 8'd2;
    drive(1, 16'h8000); step();
    drive(1, 0); step();
    n_cmp++;
    if (overload !== 1'b1 || overload !== exp_ovl) begin
      n_bad++;
      $display("FAIL sat_trip: got ovl=%0b want 1 (model %0b)", overload, exp_ovl);
    end
    clear = 1; step(); clear = 0;
    threshold = 15'd0;
    drive(1, 0); step(); step();
    n_cmp++;
    if (overload !== 1'b1 || overload !== exp_ovl) begin
      n_bad++;
      $display("FAIL zero_thr_trip: got ovl=%0b want 1 (model %0b)", overload, exp_ovl);
    end
  endtask

  task automatic test_peak();
    int pulses, v;
    clear = 1; drive(0, 0); step(); clear = 0;
    threshold = 15'h7FFF; min_hits = 4'd1;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) v = 4321;
      else if (i == 60) v = -4321;
      else if (i < 100) v = i * 43;
      else v = int'($urandom_range(0, 4320)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      drive(1, v);
      step();
      if (peak_valid) pulses++;
      n_cmp++;
      if (peak_valid !== exp_pv || peak_mag !== exp_peak[14:0]) begin
        n_bad++;
        $display("FAIL peak_win[%0d]: got pv=%0b peak=%0d want %0b/%0d", i, peak_valid, peak_mag, exp_pv, exp_peak);
      end
    end
    drive(0, 0); step();
    if (peak_valid) pulses++;
    n_cmp++;
    if (peak_valid !== 1'b1 || peak_mag !== 15'd4321 || pulses != 1) begin
      n_bad++;
      $display("FAIL peak_latch: got pv=%0b peak=%0d pulses=%0d want 1/4321/1", peak_valid, peak_mag, pulses);
    end
    for (int i = 0; i < 256; i++) begin drive(1, 0); step(); end
    drive(0, 0); step();
    n_cmp++;
    if (peak_valid !== 1'b1 || peak_mag !== 15'd0) begin
      n_bad++;
      $display("FAIL peak_zero: got pv=%0b peak=%0d want 1/0", peak_valid, peak_mag);
    end
  endtask

  task automatic test_mid_control();
    int pulses;
    clear = 1; drive(0, 0); step(); clear = 0;
    threshold = 15'd1000; min_hits = 4'd1; hold_cycles = 8'd200;
    drive(1, 2000); step();
    drive(1, 0); step();
    n_cmp++;
    if (overload !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_trip: got ovl=%0b want 1", overload);
    end
    enable = 0; step(); enable = 1;
    n_cmp++;
    if (overload !== 1'b0 || overload !== exp_ovl) begin
      n_bad++;
      $display("FAIL enable_drop: got ovl=%0b want 0 (model %0b)", overload, exp_ovl);
    end
    min_hits = 4'd2;
    drive(1, 2000); step();
    drive(0, 0); enable = 0; step(); enable = 1;
    drive(1, 2000); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0); step();
      n_cmp++;
      if (overload !== 1'b0 || overload !== exp_ovl) begin
        n_bad++;
        $display("FAIL hitcnt_cleared: got ovl=%0b want 0 (model %0b)", overload, exp_ovl);
      end
    end
    // Known window (peak 777), then a partial window of large samples cut off by clear.
    clear = 1; step(); clear = 0;
    threshold = 15'h7FFF;
    for (int i = 0; i < 256; i++) begin drive(1, (i == 17) ? -777 : int'($urandom_range(0, 776))); step(); end
    for (int i = 0; i < 100; i++) begin drive(1, 3000 + i); step(); end
    clear = 1; drive(0, 0); step(); clear = 0;
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      drive(1, int'($urandom_range(0, 2000)));
      step();
      if (peak_valid) pulses++;
    end
    drive(0, 0); step(); step();
    if (peak_valid) pulses++;
    n_cmp++;
    if (pulses != 0 || peak_mag !== 15'd777) begin
      n_bad++;
      $display("FAIL clear_window: got pulses=%0d peak=%0d want 0/777", pulses, peak_mag);
    end
    drive(1, 2001); step();
    drive(0, 0); step();
    n_cmp++;
    if (peak_valid !== 1'b1 || peak_mag !== 15'd2001 || peak_mag !== exp_peak[14:0]) begin
      n_bad++;
      $display("FAIL clear_refill: got pv=%0b peak=%0d want 1/2001 (model %0d)", peak_valid, peak_mag, exp_peak);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        threshold   = 15'($urandom_range(0, 4000));
        min_hits    = 4'($urandom_range(0, 15));
        hold_cycles = 8'($urandom_range(0, 12));
      end
      RESETn = ($urandom_range(0, 399) != 0);
      clear  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 29) != 0);
      drive($urandom_range(0, 9) < 7, ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 6000)) - 3000);
      step();
      n_cmp++;
      if (overload !== exp_ovl || peak_valid !== exp_pv || peak_mag !== exp_peak[14:0]) begin
        n_bad++;
        $display("FAIL random[%0d]: got ovl=%0b pv=%0b peak=%0d want %0b/%0b/%0d", i, overload, peak_valid, peak_mag, exp_ovl, exp_pv, exp_peak);
      end
    end
    RESETn = 1; clear = 0; enable = 1;
  endtask

  initial begin
    edge_n = 0; m_armed = 0; m_on = 0; m_run = 0; m_last_hit = 0; m_last_hold = 0;
    p_v = 0; p_h = 0; p_mag = 0; exp_peak = 0; exp_pv = 0; exp_ovl = 0;
    test_reset();
    test_trip_count();
    test_hold();
    test_edges();
    test_peak();
    test_mid_control();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
